// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences a biased dot-product on an external MAC unit.
// Flow: IDLE -> BIAS (load bias) -> ISSUE (one operand read per cycle) ->
// DRAIN (wait for the multiplier pipeline) -> DONE (capture result).
// Optional build macro MAC_SEQUENCER_RELU_EN: negative accumulator values
// (sign bit mac_out[15] set) are captured as zero.
module mac_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int MULT_LAT = 1
) (
  input  logic              clk,
  input  logic              init,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        bias_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        mac_bias,
  output logic              mac_ld_reg,
  output logic              mac_inc,
  output logic              mac_init,
  input  logic [15:0]       mac_out,
  output logic              busy,
  output logic              done,
  output logic [15:0]       result
);

  // One valid bit per in-flight read: read data takes one cycle, the
  // multiplier MULT_LAT more, so mac_inc trails rd_en by MULT_LAT+1 cycles.
  localparam int VLD_D = MULT_LAT + 1;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [7:0]          mac_bias_q, mac_bias_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [VLD_D-1:0]    vld_q, vld_d;
  logic                mac_ld_reg_q, mac_ld_reg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         result_q, result_d;

  // Next-state and next-output logic; outputs are derived from the next
  // state so that every output port comes straight from a flop.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    mac_bias_d = mac_bias_q;
    rd_addr_d  = rd_addr_q;
    result_d   = result_q;
    vld_d      = (vld_q << 1) | VLD_D'(rd_en_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = (len > MAX_LEN) ? MAX_LEN : len;
          mac_bias_d = bias_in;
          rd_addr_d  = '0;
          state_d    = BIAS;
        end
      end
      BIAS: begin
        rd_addr_d = '0;
        state_d   = (len_q == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        // The address stops at len-1; the last read hands over to DRAIN.
        if ({1'b0, rd_addr_q} == len_q - LEN_ONE) begin
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (vld_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef MAC_SEQUENCER_RELU_EN
        result_d = mac_out[15] ? 16'h0000 : mac_out;
`else
        result_d = mac_out;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_en_d      = (state_d == ISSUE);
    mac_ld_reg_d = (state_d == BIAS);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  // State and output registers with synchronous init.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    if (init) begin
      state_q      <= IDLE;
      len_q        <= '0;
      mac_bias_q   <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      vld_q        <= '0;
      mac_ld_reg_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      mac_bias_q   <= mac_bias_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      vld_q        <= vld_d;
      mac_ld_reg_q <= mac_ld_reg_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign mac_bias   = mac_bias_q;
  assign mac_ld_reg = mac_ld_reg_q;
  assign mac_inc    = vld_q[VLD_D-1];
  assign mac_init   = init;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer: an operand memory plus sign-magnitude MAC
// environment, and a reference that predicts results and cycle timing
// directly from the dot-product definition.
module tb_mac_sequencer;
  localparam int ADDR_W   = 4;
  localparam int MULT_LAT = 1;   // environment multiplier has one pipeline stage
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int MAXC     = 64;

  logic              clk = 1'b0;
  logic              init = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic [7:0]        bias_in = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        mac_bias;
  logic              mac_ld_reg, mac_inc, mac_init;
  logic [15:0]       mac_out;
  logic              busy, done;
  logic [15:0]       result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.ADDR_W(ADDR_W), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .init(init), .start(start), .len(len), .bias_in(bias_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .mac_bias(mac_bias),
    .mac_ld_reg(mac_ld_reg), .mac_inc(mac_inc), .mac_init(mac_init),
    .mac_out(mac_out), .busy(busy), .done(done), .result(result)
  );

  function automatic logic [15:0] to_sm(input int v);
    logic [31:0] m;
    m = (v < 0) ? -v : v;
    return {v < 0, m[14:0]};
  endfunction

  // ---------------- environment: operand memory and MAC ----------------
  logic signed [7:0] mem_a [DEPTH];
  logic signed [7:0] mem_b [DEPTH];
  logic signed [7:0] a_q = '0, b_q = '0;
  int prod_q = 0;
  int acc = 0;

  always @(posedge clk) begin
    if (rd_en) begin
      a_q <= mem_a[rd_addr];
      b_q <= mem_b[rd_addr];
    end
    prod_q <= int'(a_q) * int'(b_q);
    if (mac_init)        acc <= 0;
    else if (mac_ld_reg) acc <= int'($signed(mac_bias));
    else if (mac_inc)    acc <= acc + prod_q;
  end
  assign mac_out = to_sm(acc);

  // ---------------- reference model ----------------
  function automatic int clamp_len(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  function automatic int latency(input int lenc);
    return (lenc == 0) ? 2 : lenc + MULT_LAT + 3;
  endfunction

  function automatic logic [15:0] expect_result(input int lenc, input logic [7:0] b);
    int sum;
    sum = int'($signed(b));
    for (int i = 0; i < lenc; i++) sum += int'(mem_a[i]) * int'(mem_b[i]);
`ifdef MAC_SEQUENCER_RELU_EN
    if (sum < 0) return 16'h0000;
`endif
    return to_sm(sum);
  endfunction

  // ---------------- per-cycle recording and stimulus patterns ----------------
  logic            s_done[MAXC], s_busy[MAXC], s_rd[MAXC], s_ld[MAXC], s_inc[MAXC];
  logic [ADDR_W-1:0] s_addr[MAXC];
  logic [7:0]      s_bias[MAXC];
  logic [15:0]     s_res[MAXC];
  logic            p_start[MAXC], p_init[MAXC];
  logic [ADDR_W:0] p_len[MAXC];
  logic [7:0]      p_bias[MAXC];

  // Quiet start/init; len/bias get junk so later changes prove latching.
  // noise_upto > 0 sprinkles start pulses over cycles 1..noise_upto.
  task automatic clear_pat(input int noise_upto);
    for (int i = 0; i < MAXC; i++) begin
      p_start[i] = (i >= 1 && i <= noise_upto) ? 1'($urandom_range(0, 1)) : 1'b0;
      p_init[i]  = 1'b0;
      p_len[i]   = (ADDR_W + 1)'($urandom);
      p_bias[i]  = 8'($urandom);
    end
  endtask

  // Cycle 0: start is sampled at its closing edge. Cycles 1..n are recorded at
  // the falling edge; patterns for cycle k are applied right after sampling.
  task automatic observe(input int n, input logic [ADDR_W:0] l0, input logic [7:0] b0);
    @(negedge clk);
    start = 1'b1; len = l0; bias_in = b0; init = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      s_done[k] = done; s_busy[k] = busy; s_rd[k] = rd_en; s_ld[k] = mac_ld_reg;
      s_inc[k] = mac_inc; s_addr[k] = rd_addr; s_bias[k] = mac_bias; s_res[k] = result;
      start = p_start[k]; init = p_init[k]; len = p_len[k]; bias_in = p_bias[k];
    end
    start = 1'b0; init = 1'b0;
  endtask

  // Checks one operation accepted at the edge closing cycle s.
  task automatic check_op(input string name, input int s, input int lenc,
                          input logic [7:0] b, input logic [15:0] exp_res);
    int lat, last, bad;
    logic e;
    lat = latency(lenc);
    last = s + lat + 1;

    bad = -1;
    for (int k = s + 1; k <= last; k++) if (bad < 0 && s_done[k] !== (k == s + lat)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++; e = (bad == s + lat);
      $display("FAIL %s done: rel cycle %0d got %b expected %b", name, bad - s, s_done[bad], e);
    end

    bad = -1;
    for (int k = s + 1; k <= last; k++) if (bad < 0 && s_busy[k] !== (k <= s + lat)) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++; e = (bad <= s + lat);
      $display("FAIL %s busy: rel cycle %0d got %b expected %b", name, bad - s, s_busy[bad], e);
    end

    bad = -1;
    for (int k = s + 1; k <= last; k++) if (bad < 0 && s_ld[k] !== (k == s + 1)) bad = k;
    checks++;
    if (bad >= 0 || s_bias[s + 1] !== b) begin
      errors++;
      $display("FAIL %s bias_load: first bad rel cycle %0d, mac_bias got %h expected %h",
               name, bad - s, s_bias[s + 1], b);
    end

    bad = -1;
    for (int k = s + 1; k <= last; k++) begin
      e = (k >= s + 2) && (k <= s + 1 + lenc);
      if (bad < 0 && (s_rd[k] !== e || (e && s_addr[k] !== ADDR_W'(k - s - 2)))) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s read: rel cycle %0d got rd_en=%b addr=%0d expected rd_en=%b addr=%0d",
               name, bad - s, s_rd[bad], s_addr[bad],
               (bad >= s + 2) && (bad <= s + 1 + lenc), bad - s - 2);
    end

    bad = -1;
    for (int k = s + 1; k <= last; k++) begin
      e = (k >= s + MULT_LAT + 3) && (k <= s + MULT_LAT + 2 + lenc);
      if (bad < 0 && s_inc[k] !== e) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s mac_inc: rel cycle %0d got %b", name, bad - s, s_inc[bad]);
    end

    checks++;
    if (s_res[last] !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, s_res[last], exp_res);
    end
  endtask

  task automatic run_op(input string name, input int l, input logic [7:0] b, input int noise);
    int lenc;
    lenc = clamp_len(l);
    clear_pat(noise ? latency(lenc) : 0);
    observe(latency(lenc) + 1, (ADDR_W + 1)'(l), b);
    check_op(name, 0, lenc, b, expect_result(lenc, b));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    init = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (mac_init !== 1'b1) begin errors++; $display("FAIL reset_mac_init: got %b expected 1", mac_init); end
    @(negedge clk);
    init = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, rd_en, mac_ld_reg, mac_inc, mac_init} !== 6'b0 ||
          rd_addr !== '0 || mac_bias !== 8'h00 || result !== 16'h0000) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d busy=%b done=%b rd_en=%b ld=%b inc=%b init=%b addr=%0d bias=%h result=%h expected all zero",
                 c, busy, done, rd_en, mac_ld_reg, mac_inc, mac_init, rd_addr, mac_bias, result);
      end
    end
  endtask

  task automatic test_directed;
    mem_a[0] = 8'sd2; mem_a[1] = 8'sd3; mem_a[2] = 8'sd4;
    mem_b[0] = 8'sd1; mem_b[1] = 8'sd1; mem_b[2] = 8'sd1;
    run_op("directed", 3, 8'd5, 0);
    checks++;
    if (s_done[7] !== 1'b1 || s_res[8] !== 16'd14) begin
      errors++;
      $display("FAIL directed_fixed: done@7=%b result=%h expected 1 and 000e", s_done[7], s_res[8]);
    end
  endtask

  task automatic test_len0;
    run_op("len0", 0, 8'd9, 0);
    checks++;
    if (s_done[2] !== 1'b1 || s_res[3] !== 16'd9) begin
      errors++;
      $display("FAIL len0_fixed: done@2=%b result=%h expected 1 and 0009", s_done[2], s_res[3]);
    end
  endtask

  // start held from cycle 1 through cycle 7: ignored while busy and in the
  // DONE cycle (6), accepted in cycle 7 with the values presented then.
  task automatic test_back_to_back;
    logic [15:0] r1, r2;
    for (int i = 0; i < 2; i++) begin mem_a[i] = 8'(i + 3); mem_b[i] = 8'sd2; end
    clear_pat(0);
    for (int k = 1; k <= 7; k++) begin p_start[k] = 1'b1; p_len[k] = 1; p_bias[k] = 8'd7; end
    r1 = expect_result(2, 8'd1);
    r2 = expect_result(1, 8'd7);
    observe(7 + latency(1) + 1, 2, 8'd1);
    check_op("b2b_first", 0, 2, 8'd1, r1);
    check_op("b2b_second", 7, 1, 8'd7, r2);
    checks++;
    if (s_res[12] !== r1) begin
      errors++; $display("FAIL b2b_result_hold: got %h expected %h", s_res[12], r1);
    end
  endtask

  task automatic test_abort;
    int bad;
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = 8'sd1; mem_b[i] = 8'sd1; end
    clear_pat(0);
    p_init[3] = 1'b1;
    observe(20, 8, 8'd4);
    checks++;
    if (s_busy[1] !== 1'b1 || s_rd[2] !== 1'b1) begin
      errors++; $display("FAIL abort_started: busy@1=%b rd_en@2=%b expected 1 1", s_busy[1], s_rd[2]);
    end
    bad = -1;
    for (int k = 4; k <= 20; k++)
      if (bad < 0 && {s_done[k], s_busy[k], s_rd[k], s_ld[k], s_inc[k]} !== 5'b0) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL abort_quiet: cycle %0d done=%b busy=%b rd_en=%b ld=%b inc=%b expected all 0",
               bad, s_done[bad], s_busy[bad], s_rd[bad], s_ld[bad], s_inc[bad]);
    end
    checks++;
    if (s_done[3] !== 1'b0 || s_res[4] !== 16'h0000) begin
      errors++; $display("FAIL abort_result: done@3=%b result=%h expected 0 0000", s_done[3], s_res[4]);
    end
  endtask

  task automatic test_sign;
    logic [15:0] want;
`ifdef MAC_SEQUENCER_RELU_EN
    want = 16'h0000;
`else
    want = 16'h8006;
`endif
    mem_a[0] = -8'sd3; mem_b[0] = 8'sd2;
    run_op("sign", 1, 8'd0, 0);
    checks++;
    if (s_res[latency(1) + 1] !== want) begin
      errors++; $display("FAIL sign_fixed: got %h expected %h", s_res[latency(1) + 1], want);
    end
  endtask

  task automatic test_random;
    int l, t;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        t = $urandom_range(0, 40) - 20; mem_a[i] = 8'(t);
        t = $urandom_range(0, 40) - 20; mem_b[i] = 8'(t);
      end
      l = (n == 0) ? DEPTH : (n == 1) ? 31 : $urandom_range(0, 31);
      run_op($sformatf("random%0d_len%0d", n, l), l, 8'($urandom), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    test_reset();
    test_directed();
    test_len0();
    test_back_to_back();
    test_abort();
    test_sign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
